// File: rtl/pwm_audio_out.sv
// Sample FIFO feeding a frame-based PWM modulator; one sample per 2^SAMPLE_W-cycle frame.
// Optional macro PWM_UNDERRUN_HOLD_EN: repeat the last duty on underrun instead of midscale.
module pwm_audio_out #(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_aud,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifndef PWM_UNDERRUN_HOLD_EN
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};
`endif

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [SAMPLE_W-1:0] cnt, duty, duty_eff;
  logic                frame_start, fifo_empty, push, pop;

  assign sample_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_level == '0);
  assign frame_start  = enable && (cnt == '0);
  assign push         = sample_valid && sample_ready;
  assign pop          = frame_start && !fifo_empty;

  // duty_eff lets the frame-start edge compare against the value being loaded,
  // so the first high cycle lands right after the frame start.
  always_comb begin
    duty_eff = duty;
    if (frame_start) begin
      if (!fifo_empty) begin
        duty_eff = mem[rd_ptr];
      end else begin
`ifdef PWM_UNDERRUN_HOLD_EN
        duty_eff = duty;
`else
        duty_eff = MIDSCALE;
`endif
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt        <= '0;
      duty       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pwm_aud    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      cnt     <= enable ? cnt + 1'b1 : '0;
      duty    <= duty_eff;
      pwm_aud <= enable && (cnt < duty_eff);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (frame_start && fifo_empty) begin
        underrun <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: queue-based frame model plus directed frame-count checks.
module tb_pwm_audio_out;

  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 1 << SW;

  logic          sysclk;
  logic          reset;
  logic          enable;
  logic [SW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          pwm_aud;
  logic          underrun;
  logic [2:0]    fifo_level;

  int tests  = 0;
  int errors = 0;

  pwm_audio_out #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .enable       (enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_aud      (pwm_aud),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a sample queue, a position-in-frame counter and the current frame's duty.
  int unsigned q[$];
  int          pos;
  int          mduty;
  bit          munder;
  bit          mpwm;
  bit          fs;
  int          sz;

  always @(posedge sysclk) begin
    if (reset) begin
      q.delete();
      pos    = 0;
      mduty  = 0;
      munder = 0;
      mpwm   = 0;
    end else begin
      fs = enable && (pos == 0);
      sz = q.size();
      if (fs) begin
        if (sz > 0) mduty = int'(q.pop_front());
        else begin
          munder = 1;
`ifndef PWM_UNDERRUN_HOLD_EN
          mduty = FRAME / 2;
`endif
        end
      end
      if (sample_valid && sz != DEPTH) q.push_back(int'(sample_data));
      mpwm = enable && (pos < mduty);
      pos  = enable ? (pos + 1) % FRAME : 0;
    end
  end

  always @(posedge sysclk) begin
    #1;
    check("pwm_aud", int'(pwm_aud), int'(mpwm));
    check("underrun", int'(underrun), int'(munder));
    check("fifo_level", int'(fifo_level), q.size());
    check("sample_ready", int'(sample_ready), int'(q.size() != DEPTH));
  end

  task automatic push(input int v);
    @(negedge sysclk);
    sample_valid = 1'b1;
    sample_data  = SW'(v);
    @(posedge sysclk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  // Collects one full frame of output starting at the next rising edge (assumed a frame start).
  task automatic count_frame(output int hi, output int first, output int lvl0);
    hi = 0; first = 0; lvl0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge sysclk);
      #1;
      if (i == 0) begin
        first = int'(pwm_aud);
        lvl0  = int'(fifo_level);
        sample_valid = 1'b0;
      end
      hi += int'(pwm_aud);
    end
  endtask

  int hi, first, lvl0;
  int exp_uf;

  initial begin
    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample_data = '0;

    // Reset held with enable high
    repeat (100) begin
      @(posedge sysclk);
      #1;
      check("rst_pwm", int'(pwm_aud), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_level", int'(fifo_level), 0);
    end
    @(negedge sysclk);
    reset = 1'b0; enable = 1'b0;
    @(posedge sysclk);
    #1;
    check("rst_ready", int'(sample_ready), 1);

    // Steady stream
    do_reset();
    push(8'h40); push(8'h00); push(8'hFF); push(8'h80);
    @(negedge sysclk);
    enable = 1'b1;
    count_frame(hi, first, lvl0);
    check("frame_0x40_hi", hi, 64);
    check("frame_0x40_first", first, 1);
    count_frame(hi, first, lvl0);
    check("frame_0x00_hi", hi, 0);
    count_frame(hi, first, lvl0);
    check("frame_0xFF_hi", hi, 255);
    count_frame(hi, first, lvl0);
    check("frame_0x80_hi", hi, 128);
    check("stream_underrun", int'(underrun), 0);

    // Backpressure
    do_reset();
    @(negedge sysclk);
    sample_valid = 1'b1;
    repeat (10) begin
      sample_data = SW'($urandom);
      @(negedge sysclk);
    end
    sample_valid = 1'b0;
    check("bp_level", int'(fifo_level), 4);
    check("bp_ready", int'(sample_ready), 0);
    enable = 1'b1;
    @(posedge sysclk);
    #1;
    check("bp_ready_after_pop", int'(sample_ready), 1);
    check("bp_level_after_pop", int'(fifo_level), 3);

    // Underrun
    do_reset();
    push(8'h20);
    @(negedge sysclk);
    enable = 1'b1;
    count_frame(hi, first, lvl0);
    check("uf_frame1_hi", hi, 32);
    check("uf_before", int'(underrun), 0);
    count_frame(hi, first, lvl0);
`ifdef PWM_UNDERRUN_HOLD_EN
    exp_uf = 32;
`else
    exp_uf = 128;
`endif
    check("uf_frame2_hi", hi, exp_uf);
    check("uf_flag", int'(underrun), 1);

    // Push on an empty FIFO exactly at a frame start
    do_reset();
    @(negedge sysclk);
    enable = 1'b1; sample_valid = 1'b1; sample_data = 8'h30;
    count_frame(hi, first, lvl0);
`ifdef PWM_UNDERRUN_HOLD_EN
    exp_uf = 0;
`else
    exp_uf = 128;
`endif
    check("sc_frame1_hi", hi, exp_uf);
    check("sc_level_1", lvl0, 1);
    check("sc_underrun", int'(underrun), 1);
    count_frame(hi, first, lvl0);
    check("sc_frame2_hi", hi, 48);
    check("sc_level_0", lvl0, 0);

    // Disable at cnt=100, re-enable, then reset mid-frame
    do_reset();
    push(8'hC0); push(8'h10);
    @(negedge sysclk);
    enable = 1'b1;
    repeat (100) @(negedge sysclk);
    check("dis_pwm_before", int'(pwm_aud), 1);
    enable = 1'b0;
    @(posedge sysclk);
    #1;
    check("dis_pwm", int'(pwm_aud), 0);
    check("dis_level", int'(fifo_level), 1);
    @(negedge sysclk);
    enable = 1'b1;
    count_frame(hi, first, lvl0);
    check("reen_hi", hi, 16);
    check("reen_first", first, 1);
    push(8'h55); push(8'h66);
    repeat (30) @(negedge sysclk);
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    check("midrst_pwm", int'(pwm_aud), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_level", int'(fifo_level), 0);
    @(negedge sysclk);
    reset = 1'b0;

    // Randomized traffic against the model
    enable = 1'b1;
    repeat (5000) begin
      @(negedge sysclk);
      sample_valid = ($urandom_range(0, 149) == 0);
      sample_data  = SW'($urandom);
      if ($urandom_range(0, 699) == 0) enable = ~enable;
      reset = ($urandom_range(0, 2999) == 0);
    end
    @(negedge sysclk);
    reset = 1'b0; sample_valid = 1'b0;
    @(posedge sysclk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
